// File: rtl/sram_mem_controller_pkg.sv
// Shared widths and phase-state encoding for the multi-cycle SRAM data-memory controller.
package sram_mem_controller_pkg;

  localparam int unsigned WORD_LEN = 32;
  localparam int unsigned SRAM_DW  = WORD_LEN / 2;
  localparam int unsigned SRAM_AW  = 18;
  localparam int unsigned IDX_W    = SRAM_AW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into low/high half-word SRAM phases,
// holding ready low so the pipeline freezes until the word is complete.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] ST_value,
  output logic [WORD_LEN-1:0] dataMem_out,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [SRAM_DW-1:0]  sram_wdata,
  input  logic [SRAM_DW-1:0]  sram_rdata,
  output logic                sram_we_n
);

  localparam logic [3:0] CNT_LAST = 4'(PHASE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [SRAM_DW-1:0]  rlo_q, rlo_d;
  logic [WORD_LEN-1:0] dout_q, dout_d;
  logic                req;

  // Byte-offset bits and bits above the SRAM range do not select a word.
  logic unused_addr;
  assign unused_addr = ^{address[WORD_LEN-1:SRAM_AW+1], address[1:0]};

  assign req         = MEM_R_EN | MEM_W_EN;
  assign dataMem_out = dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rlo_q   <= rlo_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rlo_d      = rlo_q;
    dout_d     = dout_q;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          // A simultaneous read and write request is serviced as a write.
          wr_d    = MEM_W_EN;
          idx_d   = address[SRAM_AW:2];
          wdata_d = ST_value;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        sram_addr  = {idx_q, 1'b0};
        sram_wdata = wdata_q[SRAM_DW-1:0];
        sram_we_n  = ~wr_q;
        if (cnt_q == CNT_LAST) begin
          if (!wr_q) rlo_d = sram_rdata;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        sram_addr  = {idx_q, 1'b1};
        sram_wdata = wdata_q[WORD_LEN-1:SRAM_DW];
        sram_we_n  = ~wr_q;
        if (cnt_q == CNT_LAST) begin
          if (!wr_q) dout_d = {sram_rdata, rlo_q};
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed scenarios plus random word traffic
// checked against a word-addressed reference memory and latency rules.
module tb_sram_mem_controller;
  import sram_mem_controller_pkg::*;

  localparam int unsigned P = 2;

  logic                clk;
  logic                rst;
  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic [WORD_LEN-1:0] address;
  logic [WORD_LEN-1:0] ST_value;
  logic [WORD_LEN-1:0] dataMem_out;
  logic                ready;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [SRAM_DW-1:0]  sram_wdata;
  logic [SRAM_DW-1:0]  sram_rdata;
  logic                sram_we_n;

  sram_mem_controller #(.PHASE_CYCLES(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .address    (address),
    .ST_value   (ST_value),
    .dataMem_out(dataMem_out),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sram_model: combinational read, write on the clock edge while we_n is low.
  logic [SRAM_DW-1:0] sram [0:(1<<SRAM_AW)-1];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_wdata;
  assign sram_rdata = sram[sram_addr];

  int unsigned         checks = 0;
  int unsigned         errors = 0;
  logic [31:0]         model [int unsigned];
  int unsigned         written [$];
  logic [31:0]         exp_dout;

  function automatic int unsigned word_idx(input logic [31:0] a);
    return int'(a >> 2) % (1 << (SRAM_AW - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int unsigned frozen;
    int unsigned we_low;
    int unsigned hold_bad;
    int unsigned wi;
    bit          done;
    frozen = 0; we_low = 0; hold_bad = 0; done = 0;
    wi = word_idx(addr);
    @(posedge clk); #1;
    MEM_R_EN = rd; MEM_W_EN = wr; address = addr; ST_value = data;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!sram_we_n) we_low++;
      if (ready) done = 1;
      else begin
        frozen++;
        if (dataMem_out !== exp_dout) hold_bad++;
      end
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".freeze"}, frozen, 2 * P + 1);
    check({tag, ".we_low"}, we_low, wr ? 2 * P : 0);
    check({tag, ".hold"}, hold_bad, 0);
    if (wr) begin
      model[wi] = data;
      written.push_back(wi);
      check({tag, ".sram_lo"}, 32'(sram[2 * wi]), 32'(data[15:0]));
      check({tag, ".sram_hi"}, 32'(sram[2 * wi + 1]), 32'(data[31:16]));
    end else if (rd) begin
      exp_dout = model.exists(wi) ? model[wi] : 32'h0;
    end
    check({tag, ".dout"}, dataMem_out, exp_dout);
  endtask

  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      @(negedge clk);
      check({tag, ".idle_ready"}, 32'(ready), 32'd1);
      check({tag, ".idle_we_n"}, 32'(sram_we_n), 32'd1);
      check({tag, ".idle_dout"}, dataMem_out, exp_dout);
    end
  endtask

  initial begin
    int unsigned r;
    logic [31:0] a;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; ST_value = '0;
    exp_dout = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.we_n", 32'(sram_we_n), 32'd1);
    check("rst.dout", dataMem_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.ready", 32'(ready), 32'd1);
    check("post_rst.addr", 32'(sram_addr), 32'h0);
    check("post_rst.wdata", 32'(sram_wdata), 32'h0);

    access(1'b0, 1'b1, 32'h10, 32'h12345678, "st10");
    check("st10.sram8", 32'(sram[8]), 32'h5678);
    check("st10.sram9", 32'(sram[9]), 32'h1234);
    idle(1, "g0");
    access(1'b1, 1'b0, 32'h10, 32'h0, "ld10");
    check("ld10.value", dataMem_out, 32'h12345678);
    idle(3, "ld10");

    access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, "st20");
    access(1'b1, 1'b0, 32'h20, 32'h0, "ld20_b2b");
    check("ld20.value", dataMem_out, 32'hDEADBEEF);
    idle(1, "g1");

    access(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, "both");
    check("both.sram2", 32'(sram[2]), 32'hF00D);
    check("both.sram3", 32'(sram[3]), 32'hCAFE);
    check("both.dout", dataMem_out, 32'hDEADBEEF);
    idle(1, "g2");

    // Reset in the HIGH phase of a load: t0 IDLE, P cycles LOW, then HIGH.
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = 32'h10;
    repeat (P + 1) @(posedge clk);
    #2;
    check("mid.high_addr", 32'(sram_addr), 32'h9);
    rst = 1'b1; MEM_R_EN = 1'b0;
    exp_dout = 32'h0;
    #1;
    check("mid.rst_ready", 32'(ready), 32'd1);
    check("mid.rst_we_n", 32'(sram_we_n), 32'd1);
    check("mid.rst_dout", dataMem_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid.after_ready", 32'(ready), 32'd1);
    check("mid.after_we_n", 32'(sram_we_n), 32'd1);
    check("mid.after_dout", dataMem_out, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, "ld_after_rst");
    check("ld_after_rst.value", dataMem_out, 32'h12345678);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      if (r == 0 || written.size() == 0) begin
        access(1'b0, 1'b1, $urandom, $urandom, $sformatf("rnd%0d.wr", n));
      end else if (r == 1) begin
        access(1'b1, 1'b1, $urandom, $urandom, $sformatf("rnd%0d.both", n));
      end else begin
        // Alias the stored word through random high bits and byte offset.
        a = ($urandom << (SRAM_AW + 1)) | (32'(written[$urandom_range(0, written.size() - 1)]) << 2)
            | ($urandom & 32'h3);
        access(1'b1, 1'b0, a, $urandom, $sformatf("rnd%0d.rd", n));
      end
      idle($urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
